// File: rtl/cordic_iter_engine.sv
// rtl/cordic_iter_engine.sv - iterative circular/hyperbolic CORDIC micro-rotation engine
// Optional sticky x/y overflow flag: define CORDIC_OVERFLOW_EN.
module cordic_iter_engine #(
  parameter int p_WIDTH            = 32,
  parameter int p_ANGLE_ADDR_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              system,
  input  logic                              mode,
  input  logic [p_ANGLE_ADDR_WIDTH-1:0]     iterCount,
  input  logic signed [p_WIDTH-1:0]         xIn,
  input  logic signed [p_WIDTH-1:0]         yIn,
  input  logic signed [p_WIDTH-1:0]         zIn,
  output logic signed [p_WIDTH-1:0]         xOut,
  output logic signed [p_WIDTH-1:0]         yOut,
  output logic signed [p_WIDTH-1:0]         zOut,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow,
  output logic [p_ANGLE_ADDR_WIDTH-1:0]     lutOffset,
  output logic                              lutSystem,
  input  logic [p_WIDTH-1:0]                lutAngle
);

  localparam int W  = p_WIDTH;
  localparam int AW = p_ANGLE_ADDR_WIDTH;
  localparam logic [AW-1:0] c_ONE   = AW'(1);
  localparam logic [AW-1:0] c_REP_A = AW'(4);
  localparam logic [AW-1:0] c_REP_B = AW'(13);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t              state;
  logic signed [W-1:0] xReg, yReg, zReg;
  logic                modeReg;
  logic [AW-1:0]       iterReg;
  logic [AW-1:0]       kReg;
  logic                repeatIssued;

  logic                dirPos;
  logic                xSub;
  logic                lastIter;
  logic signed [W-1:0] xShift, yShift;
  logic signed [W-1:0] xNext, yNext, zNext;

  // lutSystem doubles as the latched system select; lutOffset is the shift index i.
  always_comb begin
    dirPos   = modeReg ? yReg[W-1] : ~zReg[W-1];
    xSub     = (dirPos == lutSystem);
    xShift   = xReg >>> lutOffset;
    yShift   = yReg >>> lutOffset;
    zNext    = dirPos ? (zReg - lutAngle) : (zReg + lutAngle);
    xNext    = xSub ? (xReg - yShift) : (xReg + yShift);
    yNext    = dirPos ? (yReg + xShift) : (yReg - xShift);
    lastIter = (kReg == iterReg - c_ONE);
  end

`ifdef CORDIC_OVERFLOW_EN
  logic [W:0] xWide, yWide;
  logic       iterOvf;

  // Same x/y sums one bit wider; a top-two-bit disagreement means the wrapped result lied.
  always_comb begin
    xWide   = xSub ? ({xReg[W-1], xReg} - {yShift[W-1], yShift})
                   : ({xReg[W-1], xReg} + {yShift[W-1], yShift});
    yWide   = dirPos ? ({yReg[W-1], yReg} + {xShift[W-1], xShift})
                     : ({yReg[W-1], yReg} - {xShift[W-1], xShift});
    iterOvf = (xWide[W] != xWide[W-1]) || (yWide[W] != yWide[W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (state == S_IDLE && start) begin
      overflow <= 1'b0;
    end else if (state == S_ITER && iterOvf) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      xReg         <= '0;
      yReg         <= '0;
      zReg         <= '0;
      xOut         <= '0;
      yOut         <= '0;
      zOut         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      lutOffset    <= '0;
      lutSystem    <= 1'b0;
      modeReg      <= 1'b0;
      iterReg      <= '0;
      kReg         <= '0;
      repeatIssued <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            xReg         <= xIn;
            yReg         <= yIn;
            zReg         <= zIn;
            lutSystem    <= system;
            modeReg      <= mode;
            iterReg      <= iterCount;
            kReg         <= '0;
            repeatIssued <= 1'b0;
            lutOffset    <= system ? '0 : c_ONE;
            if (iterCount == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
              xOut  <= xIn;
              yOut  <= yIn;
              zOut  <= zIn;
            end else begin
              state <= S_ITER;
              busy  <= 1'b1;
            end
          end
        end

        S_ITER: begin
          xReg <= xNext;
          yReg <= yNext;
          zReg <= zNext;
          kReg <= kReg + c_ONE;
          if (lastIter) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            xOut  <= xNext;
            yOut  <= yNext;
            zOut  <= zNext;
          end else if (!lutSystem && !repeatIssued &&
                       (lutOffset == c_REP_A || lutOffset == c_REP_B)) begin
            // Hyperbolic convergence needs indices 4 and 13 issued twice.
            repeatIssued <= 1'b1;
          end else begin
            repeatIssued <= 1'b0;
            if (lutOffset != '1) begin
              lutOffset <= lutOffset + c_ONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
